timer_int_ctrl: RTL and testbench
=================================

Name: timer_int_ctrl

Overview:
- Compare/interrupt stage directly downstream of the 64-bit timer counter.
- Holds the 64-bit compare value (TCMR0 low / TCMR1 high), detects counter-equals-compare and keeps a sticky interrupt status (TISR, write-1-to-clear).
- Gates the interrupt with an enable (TIER) and drives the level interrupt `tim_int`.
- Also generates the counter's debug-halt condition from THCSR and `dbg_mode`.

Parameters:
- CMP_RST_LO, 32'hFFFF_FFFF, reset value of TCMR0.
- CMP_RST_HI, 32'hFFFF_FFFF, reset value of TCMR1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- cnt_value  input  64  current counter value from the counter stage
- wdata  input  32  register write data
- tcmr0_wr_sel  input  1  write strobe, TCMR0
- tcmr1_wr_sel  input  1  write strobe, TCMR1
- tier_wr_sel  input  1  write strobe, TIER (bit0 = int_en)
- tisr_wr_sel  input  1  write strobe, TISR (bit0 W1C)
- thcsr_wr_sel  input  1  write strobe, THCSR (bit0 = halt_req)
- dbg_mode  input  1  CPU debug-mode indication
- tcmr0  output  32  compare low word
- tcmr1  output  32  compare high word
- int_en  output  1  TIER.bit0
- int_st  output  1  TISR.bit0 sticky status
- halt_req  output  1  THCSR.bit0
- halt_ack  output  1  registered halt acknowledge
- valid_halt_condition  output  1  halt_req & dbg_mode, to counter
- tim_int  output  1  int_st & int_en

Behaviour:
- Reset, asynchronous on rst=1:
  - tcmr0=CMP_RST_LO, tcmr1=CMP_RST_HI
  - int_en=0, int_st=0, halt_req=0, halt_ack=0
  - internal match_q=0
- Reset mid-operation clears everything above immediately; no pending state survives.
- Register writes:
  - Single-cycle, take effect at the rising edge where the strobe is high.
  - Strobes are mutually exclusive by the decoder; if several are high, each addressed register still updates independently.
  - TIER and THCSR write only bit0; other wdata bits are ignored.
- Match detect:
  - match = ({tcmr1,tcmr0} == cnt_value), full 64-bit unsigned equality.
  - match_q <= match every cycle.
- Status set:
  - int_st <= 1 at the edge where match=1 and match_q=0 (rising edge of equality).
  - Latency: equality first present in cycle N means int_st=1 from cycle N+1.
  - A counter held by halt at the compare value sets int_st only once.
- Status clear:
  - tisr_wr_sel with wdata[0]=1 clears int_st; wdata[0]=0 has no effect.
  - Simultaneous set and clear in one cycle: set wins, int_st stays 1.
- Compare rewrite:
  - A compare write that creates a new equality is a rising edge on the following cycle and sets int_st.
  - A write that breaks equality re-arms detection.
- Wrap-around: counter wrap from 64'hFFFF_FFFF_FFFF_FFFF to 0 needs no special handling; a compare of 0 matches after the wrap.
- tim_int and valid_halt_condition are combinational from registered state and inputs.
- halt_ack <= valid_halt_condition: one cycle latency, deasserts one cycle after halt_req or dbg_mode drops.

Optional Feature:
- Macro TIMER_CMP_SHADOW_EN.
- Defined:
  - A TCMR1 write lands in a 32-bit shadow register (reset CMP_RST_HI); tcmr1 output is unchanged.
  - A TCMR0 write updates tcmr0 and copies the shadow into tcmr1 at the same edge, giving an atomic 64-bit compare update.
  - Match detection uses only committed values.
- Not defined: TCMR1 writes go directly to tcmr1; no shadow register exists.

Decomposition:
- Shared package timer_pkg:
  - register bit positions (INT_EN_BIT=0, INT_ST_BIT=0, HALT_REQ_BIT=0)
  - compare reset constants
  - 32/64-bit width localparams
- One natural sub-module: timer_halt_ctrl (halt_req register, valid_halt_condition, halt_ack).
- Compare/interrupt logic stays in the top.

Test Plan:
1. Reset then no writes, cnt_value sweeps 0..100 -> int_st=0, tim_int=0, tcmr0/1=FFFF_FFFF.
2. TCMR1=0, TCMR0=10, TIER=1, cnt_value steps 8,9,10,11 -> int_st rises the cycle after cnt_value=10, tim_int=1; TISR write 1 -> int_st=0 next cycle and stays 0 at 11.
3. Compare=5, cnt_value held at 5 for 20 cycles -> int_st set once; W1C clear during the hold -> stays 0; TISR write coincident with the first-match edge -> int_st=1.
4. Compare=0, cnt_value FFFF_FFFF_FFFF_FFFE -> ..FFFF -> 0 -> int_st set after 0; TIER=0 -> int_st=1 but tim_int=0.
5. THCSR=1 with dbg_mode=0 -> valid_halt_condition=0; dbg_mode=1 -> valid_halt_condition=1 immediately, halt_ack=1 one cycle later; assert rst mid-halt -> all outputs return to reset values asynchronously.
6. (TIMER_CMP_SHADOW_EN) TCMR1=1 with cnt_value={32'h0,32'h20}, TCMR0=0x20 -> tcmr1 stays FFFF_FFFF until TCMR0 write; no spurious match with compare {1,0x20}.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the timer compare/interrupt stage: widths, register bit
// positions and compare reset values.
package timer_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 64;

  localparam int INT_EN_BIT   = 0;
  localparam int INT_ST_BIT   = 0;
  localparam int HALT_REQ_BIT = 0;

  localparam logic [DATA_W-1:0] CMP_RST_LO_DEF = 32'hFFFF_FFFF;
  localparam logic [DATA_W-1:0] CMP_RST_HI_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/timer_halt_ctrl.sv
// Debug-halt control: THCSR.halt_req register, combinational halt condition
// toward the counter and a one-cycle registered acknowledge.
module timer_halt_ctrl (
  input  logic clk_i,
  input  logic rst_i,
  input  logic wr_sel_i,
  input  logic wr_bit_i,
  input  logic dbg_mode_i,
  output logic halt_req_o,
  output logic halt_ack_o,
  output logic valid_halt_condition_o
);

  logic halt_req_q, halt_req_d;
  logic halt_ack_q, halt_ack_d;
  logic valid_halt;

  assign valid_halt = halt_req_q & dbg_mode_i;

  always_comb begin
    halt_req_d = halt_req_q;
    if (wr_sel_i) halt_req_d = wr_bit_i;
    halt_ack_d = valid_halt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      halt_req_q <= 1'b0;
      halt_ack_q <= 1'b0;
    end else begin
      halt_req_q <= halt_req_d;
      halt_ack_q <= halt_ack_d;
    end
  end

  assign halt_req_o             = halt_req_q;
  assign halt_ack_o             = halt_ack_q;
  assign valid_halt_condition_o = valid_halt;

endmodule

// File: rtl/timer_int_ctrl.sv
// Timer compare/interrupt stage: 64-bit compare, sticky W1C match status,
// gated level interrupt and debug-halt. TIMER_CMP_SHADOW_EN buffers TCMR1 in a shadow register.
module timer_int_ctrl
  import timer_pkg::*;
#(
  parameter logic [DATA_W-1:0] CMP_RST_LO = CMP_RST_LO_DEF,
  parameter logic [DATA_W-1:0] CMP_RST_HI = CMP_RST_HI_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cnt_value,
  input  logic [DATA_W-1:0] wdata,
  input  logic              tcmr0_wr_sel,
  input  logic              tcmr1_wr_sel,
  input  logic              tier_wr_sel,
  input  logic              tisr_wr_sel,
  input  logic              thcsr_wr_sel,
  input  logic              dbg_mode,
  output logic [DATA_W-1:0] tcmr0,
  output logic [DATA_W-1:0] tcmr1,
  output logic              int_en,
  output logic              int_st,
  output logic              halt_req,
  output logic              halt_ack,
  output logic              valid_halt_condition,
  output logic              tim_int
);

  logic [DATA_W-1:0] tcmr0_q, tcmr0_d;
  logic [DATA_W-1:0] tcmr1_q, tcmr1_d;
  logic              int_en_q, int_en_d;
  logic              int_st_q, int_st_d;
  logic              match_q, match_d;
  logic              match;

  // Only committed compare words take part in the equality check.
  assign match = ({tcmr1_q, tcmr0_q} == cnt_value);

`ifdef TIMER_CMP_SHADOW_EN
  logic [DATA_W-1:0] shadow_q, shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (tcmr1_wr_sel) shadow_d = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) shadow_q <= CMP_RST_HI;
    else     shadow_q <= shadow_d;
  end

  always_comb begin
    tcmr1_d = tcmr1_q;
    if (tcmr0_wr_sel) tcmr1_d = shadow_q;
  end
`else
  always_comb begin
    tcmr1_d = tcmr1_q;
    if (tcmr1_wr_sel) tcmr1_d = wdata;
  end
`endif

  always_comb begin
    tcmr0_d = tcmr0_q;
    if (tcmr0_wr_sel) tcmr0_d = wdata;
    int_en_d = int_en_q;
    if (tier_wr_sel) int_en_d = wdata[INT_EN_BIT];
    match_d = match;
    // A new equality edge outranks a same-cycle W1C clear.
    int_st_d = int_st_q;
    if (match && !match_q)
      int_st_d = 1'b1;
    else if (tisr_wr_sel && wdata[INT_ST_BIT])
      int_st_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcmr0_q  <= CMP_RST_LO;
      tcmr1_q  <= CMP_RST_HI;
      int_en_q <= 1'b0;
      int_st_q <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      tcmr0_q  <= tcmr0_d;
      tcmr1_q  <= tcmr1_d;
      int_en_q <= int_en_d;
      int_st_q <= int_st_d;
      match_q  <= match_d;
    end
  end

  timer_halt_ctrl u_halt (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .wr_sel_i               (thcsr_wr_sel),
    .wr_bit_i               (wdata[HALT_REQ_BIT]),
    .dbg_mode_i             (dbg_mode),
    .halt_req_o             (halt_req),
    .halt_ack_o             (halt_ack),
    .valid_halt_condition_o (valid_halt_condition)
  );

  assign tcmr0   = tcmr0_q;
  assign tcmr1   = tcmr1_q;
  assign int_en  = int_en_q;
  assign int_st  = int_st_q;
  assign tim_int = int_st_q & int_en_q;

endmodule

// File: tb/tb_timer_int_ctrl.sv
// Directed bench for timer_int_ctrl: vector table for compare/status/enable
// plus hand sequences for hold, halt, async reset and TIMER_CMP_SHADOW_EN.
module tb_timer_int_ctrl;

  localparam logic [4:0] W_NONE  = 5'b00000;
  localparam logic [4:0] W_TCMR0 = 5'b10000;
  localparam logic [4:0] W_TCMR1 = 5'b01000;
  localparam logic [4:0] W_TIER  = 5'b00100;
  localparam logic [4:0] W_TISR  = 5'b00010;
  localparam logic [4:0] W_THCSR = 5'b00001;
  localparam logic [31:0] ONES   = 32'hFFFF_FFFF;

  typedef struct {
    logic [63:0] cnt;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic [31:0] exp_tcmr0;
    logic [31:0] exp_tcmr1;
    logic        exp_int_en;
    logic        exp_int_st;
    logic        exp_tim_int;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] cnt_value = '0;
  logic [31:0] wdata = '0;
  logic        tcmr0_wr_sel = 1'b0, tcmr1_wr_sel = 1'b0, tier_wr_sel = 1'b0;
  logic        tisr_wr_sel = 1'b0, thcsr_wr_sel = 1'b0, dbg_mode = 1'b0;
  logic [31:0] tcmr0, tcmr1;
  logic        int_en, int_st, halt_req, halt_ack, valid_halt_condition, tim_int;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[14];
  logic [31:0] row0_tcmr1;
  logic [31:0] shd_tcmr1;

  always #5 clk = ~clk;

  timer_int_ctrl dut (
    .clk(clk), .rst(rst), .cnt_value(cnt_value), .wdata(wdata),
    .tcmr0_wr_sel(tcmr0_wr_sel), .tcmr1_wr_sel(tcmr1_wr_sel),
    .tier_wr_sel(tier_wr_sel), .tisr_wr_sel(tisr_wr_sel),
    .thcsr_wr_sel(thcsr_wr_sel), .dbg_mode(dbg_mode),
    .tcmr0(tcmr0), .tcmr1(tcmr1), .int_en(int_en), .int_st(int_st),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .valid_halt_condition(valid_halt_condition), .tim_int(tim_int)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [63:0] c, input logic [31:0] d, input logic [4:0] wr);
    cnt_value    = c;
    wdata        = d;
    tcmr0_wr_sel = wr[4];
    tcmr1_wr_sel = wr[3];
    tier_wr_sel  = wr[2];
    tisr_wr_sel  = wr[1];
    thcsr_wr_sel = wr[0];
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_tcmr0"}, tcmr0, ONES);
    chk({tag, "_tcmr1"}, tcmr1, ONES);
    chk({tag, "_int_en"}, int_en, 0);
    chk({tag, "_int_st"}, int_st, 0);
    chk({tag, "_tim_int"}, tim_int, 0);
    chk({tag, "_halt_req"}, halt_req, 0);
    chk({tag, "_halt_ack"}, halt_ack, 0);
    chk({tag, "_vhc"}, valid_halt_condition, 0);
  endtask

  initial begin
`ifdef TIMER_CMP_SHADOW_EN
    row0_tcmr1 = ONES;
    shd_tcmr1  = ONES;
`else
    row0_tcmr1 = 32'h0;
    shd_tcmr1  = 32'h1;
`endif
    //            cnt                     wd     wr       tcmr0  tcmr1       en st tim
    vecs[0]  = '{64'd8,                 32'd0,  W_TCMR1, ONES,  row0_tcmr1, 0, 0, 0};
    vecs[1]  = '{64'd8,                 32'd10, W_TCMR0, 32'd10, 32'd0,     0, 0, 0};
    vecs[2]  = '{64'd8,                 32'd1,  W_TIER,  32'd10, 32'd0,     1, 0, 0};
    vecs[3]  = '{64'd9,                 32'd0,  W_NONE,  32'd10, 32'd0,     1, 0, 0};
    vecs[4]  = '{64'd10,                32'd0,  W_NONE,  32'd10, 32'd0,     1, 1, 1};
    vecs[5]  = '{64'd11,                32'd1,  W_TISR,  32'd10, 32'd0,     1, 0, 0};
    vecs[6]  = '{64'd11,                32'd0,  W_NONE,  32'd10, 32'd0,     1, 0, 0};
    vecs[7]  = '{64'hFFFF_FFFF_FFFF_FFFE, 32'd0, W_TCMR0, 32'd0, 32'd0,     1, 0, 0};
    vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 32'd0, W_NONE,  32'd0, 32'd0,     1, 0, 0};
    vecs[9]  = '{64'd0,                 32'd0,  W_NONE,  32'd0,  32'd0,     1, 1, 1};
    vecs[10] = '{64'd1,                 32'd0,  W_TIER,  32'd0,  32'd0,     0, 1, 0};
    vecs[11] = '{64'd1,                 32'd2,  W_TISR,  32'd0,  32'd0,     0, 1, 0};
    vecs[12] = '{64'd1,                 ONES,   W_TIER,  32'd0,  32'd0,     1, 1, 1};
    vecs[13] = '{64'd1,                 32'd1,  W_TISR,  32'd0,  32'd0,     1, 0, 0};

    // Reset state
    drive(64'd0, 32'd0, W_NONE);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("rst");
    rst = 1'b0;

    // Counter sweep with reset compare: never matches
    for (int i = 0; i <= 100; i++) begin
      drive(64'(i), 32'd0, W_NONE);
      tick;
      chk("sweep_int_st", int_st, 0);
      chk("sweep_tim_int", tim_int, 0);
    end
    chk("sweep_tcmr0", tcmr0, ONES);
    chk("sweep_tcmr1", tcmr1, ONES);

    // Vector table: match edge, W1C, wrap-around, enable gating
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].cnt, vecs[i].wd, vecs[i].wr);
      tick;
      chk($sformatf("v%0d_tcmr0", i), tcmr0, vecs[i].exp_tcmr0);
      chk($sformatf("v%0d_tcmr1", i), tcmr1, vecs[i].exp_tcmr1);
      chk($sformatf("v%0d_int_en", i), int_en, vecs[i].exp_int_en);
      chk($sformatf("v%0d_int_st", i), int_st, vecs[i].exp_int_st);
      chk($sformatf("v%0d_tim_int", i), tim_int, vecs[i].exp_tim_int);
    end

    // Hold at compare: set once, clear sticks, set beats coincident clear
    drive(64'd3, 32'd5, W_TCMR0);
    tick;
    chk("hold_pre_int_st", int_st, 0);
    drive(64'd5, 32'd1, W_TISR);
    tick;
    chk("hold_setwins_int_st", int_st, 1);
    for (int i = 0; i < 5; i++) begin
      drive(64'd5, 32'd0, W_NONE);
      tick;
      chk("hold_sticky_int_st", int_st, 1);
    end
    drive(64'd5, 32'd1, W_TISR);
    tick;
    chk("hold_clr_int_st", int_st, 0);
    for (int i = 0; i < 13; i++) begin
      drive(64'd5, 32'd0, W_NONE);
      tick;
      chk("hold_once_int_st", int_st, 0);
    end

    // Compare rewrite: break equality, restore it, expect a fresh edge
    drive(64'd5, 32'd6, W_TCMR0);
    tick;
    chk("rew_break_int_st", int_st, 0);
    drive(64'd5, 32'd5, W_TCMR0);
    tick;
    chk("rew_restore_int_st", int_st, 0);
    drive(64'd5, 32'd0, W_NONE);
    tick;
    chk("rew_edge_int_st", int_st, 1);
    chk("rew_edge_tim_int", tim_int, 1);

    // Debug halt
    drive(64'd5, 32'hFFFF_FFFE, W_THCSR);
    tick;
    chk("halt_bit0_only", halt_req, 0);
    drive(64'd5, 32'd1, W_THCSR);
    tick;
    chk("halt_req_set", halt_req, 1);
    chk("halt_nodbg_vhc", valid_halt_condition, 0);
    chk("halt_nodbg_ack", halt_ack, 0);
    drive(64'd5, 32'd0, W_NONE);
    dbg_mode = 1'b1;
    #1;
    chk("halt_dbg_vhc_now", valid_halt_condition, 1);
    chk("halt_dbg_ack_not_yet", halt_ack, 0);
    tick;
    chk("halt_dbg_ack", halt_ack, 1);
    dbg_mode = 1'b0;
    #1;
    chk("halt_drop_vhc", valid_halt_condition, 0);
    chk("halt_drop_ack_held", halt_ack, 1);
    tick;
    chk("halt_drop_ack", halt_ack, 0);
    dbg_mode = 1'b1;
    tick;
    chk("halt_again_ack", halt_ack, 1);
    chk("halt_again_int_st", int_st, 1);

    // Asynchronous reset mid-halt, away from any clock edge
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state("arst");
    @(negedge clk);
    rst = 1'b0;
    dbg_mode = 1'b0;
    drive(64'd5, 32'd0, W_NONE);
    tick;
    chk("post_arst_int_st", int_st, 0);
    chk("post_arst_halt_ack", halt_ack, 0);

    // TCMR1 then TCMR0: shadow commit and no spurious match
    drive({32'h0, 32'h20}, 32'h1, W_TCMR1);
    tick;
    chk("shd_tcmr1_after_hi", tcmr1, shd_tcmr1);
    chk("shd_int_st_a", int_st, 0);
    drive({32'h0, 32'h20}, 32'h20, W_TCMR0);
    tick;
    chk("shd_tcmr0", tcmr0, 32'h20);
    chk("shd_tcmr1_commit", tcmr1, 32'h1);
    chk("shd_int_st_b", int_st, 0);
    drive({32'h0, 32'h20}, 32'h0, W_NONE);
    tick;
    chk("shd_no_spurious", int_st, 0);
    drive({32'h1, 32'h20}, 32'h0, W_NONE);
    tick;
    chk("shd_full_match", int_st, 1);
    chk("shd_gated_tim_int", tim_int, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
